instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Multi-cycle instruction fetch stage for the simpleRisc core. It owns the architectural program counter and issues one word-addressed request at a time to instruction memory. It registers the returned word and presents the `pc`/`instruction` pair to decode and the immediate generator under a valid/ready handshake. It also accepts redirects (branch, call, return) from execute and halts cleanly.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `PC_INC`, 1, PC increment per instruction (PC is a word address; branch targets arrive already absolute)
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  word address of request
- `imem_gnt`  in  1  request accepted this cycle (req & gnt = issued)
- `imem_rvalid`  in  1  read data valid, never earlier than the cycle after gnt
- `imem_rdata`  in  32  instruction word
- `if_valid`  out  1  `if_pc`/`if_instruction` hold a fetched instruction
- `if_ready`  in  1  downstream consumes when `if_valid & if_ready`
- `if_pc`  out  32  address of held instruction
- `if_instruction`  out  32  held instruction word
- `redirect`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new fetch address
- `halt`  in  1  level; stop issuing new requests

## Operation
- Registers: `fetch_pc` (next address to request), `drop` (discard pending response), state, output registers.
- States: IDLE, REQ, WAIT, HOLD, HALTED. Reset state IDLE.
- IDLE: `imem_req`=0; next cycle -> REQ.
- REQ: `imem_req`=1, `imem_addr`=`fetch_pc`. On gnt -> WAIT. Without gnt, stay; memory samples the address only on req&gnt, so the address may change before grant.
- WAIT: on `imem_rvalid`, either capture `imem_rdata` into `if_instruction` and the issued address into `if_pc`, then set `if_valid`=1 and go to HOLD; or, if `drop`=1, discard it, clear `drop` and go to REQ (or HALTED if `halt`).
- HOLD: on `if_valid & if_ready`, clear `if_valid` and set `fetch_pc` += `PC_INC` (mod 2^32). Then go to REQ, or to HALTED if `halt`=1.
- HALTED: `imem_req`=0, `if_valid`=0; leave only on redirect (-> REQ) or reset.
- `halt` is sampled only at the request boundaries above. An outstanding request always completes.
- Redirect has the highest priority in every state. `fetch_pc` <= `redirect_pc` next cycle.
  - IDLE/REQ without gnt: next request uses `redirect_pc`.
  - REQ with gnt in the same cycle: the request counts as issued. Go to WAIT with `drop`=1.
  - WAIT: set `drop`=1. If rvalid arrives the same cycle, discard that word and go to REQ.
  - HOLD: the held instruction is flushed (`if_valid`<=0), even if `if_ready`=1 that cycle; no transfer counted. Go to REQ.
  - HALTED: go to REQ.
- `redirect` and `halt` together: the redirect is applied, then halt takes effect at the next boundary.
- `imem_rvalid` while not in WAIT is ignored.
- Reset mid-transaction: all state is cleared and any later `imem_rvalid` is ignored, because the block is in IDLE/REQ.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instruction`=0, `fetch_pc`=`RESET_PC`, `drop`=0.
- `if_*` outputs are registered. `imem_req`/`imem_addr` are decoded from state and `fetch_pc` only, with no combinational path from any input.
- Zero-wait memory (gnt immediately, rvalid the next cycle) with `if_ready` held high gives one instruction per 3 cycles: REQ, WAIT, HOLD.
- After reset deassertion, the first `imem_req` is seen in cycle 2 and the first `if_valid` no earlier than cycle 4.
- Redirect to the first request at `redirect_pc` takes 1 cycle, plus any pending drop.

## Structure
- Shared core package holds the state enum, `RESET_PC` default and `PC_INC`, so that decode and the branch unit use the same PC arithmetic.
- Single module, no sub-module. The FSM and PC register are small enough to keep together.

## Test plan
- Reset release, zero-wait memory, `if_ready`=1: requests at 0,1,2,3. `if_pc`/`if_instruction` pairs match memory, one instruction every 3 cycles, first `if_valid` at cycle 4.
- `if_ready` low for 5 cycles in HOLD: `if_pc`/`if_instruction` stay stable, no new `imem_req`. Fetch resumes at `pc`+1 after ready.
- Redirect to 32'h40 while in WAIT with rvalid delayed 3 cycles: stale word discarded, never `if_valid`. Next request address is 32'h40.
- Redirect to 32'h80 in HOLD with `if_ready`=1 in the same cycle: held instruction flushed, no transfer. Next `if_pc`=32'h80.
- `halt` during WAIT: response delivered, then no further `imem_req` after consume. A later redirect to 32'h10 resumes fetch at 32'h10.
- `rst_n` asserted while WAIT is outstanding, then a late `imem_rvalid` with rdata 32'hDEAD_BEEF: ignored. Outputs are at reset values, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg
// Shared core definitions for the simpleRisc fetch path: fetch FSM state
// encoding, reset PC and per-instruction PC step. Decode and the branch unit
// import the same PC arithmetic so all of them agree on word addressing.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IFU_PC_INC   = 32'h0000_0001;

    typedef enum logic [2:0] {
        IFU_IDLE   = 3'd0,
        IFU_REQ    = 3'd1,
        IFU_WAIT   = 3'd2,
        IFU_HOLD   = 3'd3,
        IFU_HALTED = 3'd4
    } ifu_state_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Multi-cycle fetch stage: owns the program counter, issues one word-addressed
// request at a time, registers the returned word and hands pc/instruction to
// decode under valid/ready. Accepts redirects from execute and a level halt.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr              request to instruction memory (from state/fetch_pc only)
//   imem_gnt                        request accepted this cycle
//   imem_rvalid/imem_rdata          returned instruction word
//   if_valid/if_ready               handshake to decode
//   if_pc/if_instruction            held instruction and its address
//   redirect/redirect_pc            flush and restart fetch at redirect_pc
//   halt                            stop issuing at the next request boundary
//
// state   | meaning
// IDLE    | post-reset bubble, no request
// REQ     | imem_req high at fetch_pc, waiting for grant
// WAIT    | request issued, waiting for rvalid (discarded if drop)
// HOLD    | if_valid high, waiting for downstream to consume
// HALTED  | no requests until redirect or reset
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] PC_INC   = IFU_PC_INC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    ifu_state_t  state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic        drop, drop_next;
    logic        valid_next;
    logic        capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IFU_IDLE;
            fetch_pc       <= RESET_PC;
            drop           <= 1'b0;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_instruction <= 32'h0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop     <= drop_next;
            if_valid <= valid_next;
            // fetch_pc is unchanged since issue whenever drop is clear,
            // so it still names the word being captured.
            if (capture) begin
                if_pc          <= fetch_pc;
                if_instruction <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        drop_next     = drop;
        valid_next    = if_valid;
        capture       = 1'b0;

        case (state)
            IFU_IDLE: state_next = IFU_REQ;
            IFU_REQ: begin
                if (imem_gnt) state_next = IFU_WAIT;
            end
            IFU_WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = halt ? IFU_HALTED : IFU_REQ;
                    end else begin
                        capture    = 1'b1;
                        valid_next = 1'b1;
                        state_next = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (if_ready) begin
                    valid_next    = 1'b0;
                    fetch_pc_next = pc_step(fetch_pc, PC_INC);
                    state_next    = halt ? IFU_HALTED : IFU_REQ;
                end
            end
            IFU_HALTED: valid_next = 1'b0;
            default: begin
                state_next = IFU_IDLE;
                valid_next = 1'b0;
                drop_next  = 1'b0;
            end
        endcase

        // Redirect overrides everything above; halt waits for the next boundary.
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            capture       = 1'b0;
            valid_next    = 1'b0;
            case (state)
                IFU_REQ: begin
                    if (imem_gnt) begin
                        state_next = IFU_WAIT;
                        drop_next  = 1'b1;
                    end else begin
                        state_next = IFU_REQ;
                    end
                end
                IFU_WAIT: begin
                    if (imem_rvalid) begin
                        state_next = IFU_REQ;
                        drop_next  = 1'b0;
                    end else begin
                        state_next = IFU_WAIT;
                        drop_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = IFU_REQ;
                    drop_next  = 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = (state == IFU_REQ);
    assign imem_addr = fetch_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit with a behavioural instruction
// memory whose response latency is set per scenario.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    int n_checks = 0;
    int n_errors = 0;

    // memory model controls
    logic        gnt_en;
    int          rv_delay;
    logic        use_late;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, {31'h0, if_valid}, 32'h1);
    endtask

    // Memory responder: decides at each falling edge what the next rising
    // edge sees. A request seen with grant here is issued at that edge and
    // answered rv_delay cycles later.
    initial begin
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_addr   = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_gnt    = gnt_en;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = use_late ? 32'hDEAD_BEEF : mem_word(pend_addr);
                    pend        = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (imem_req && imem_gnt) begin
                pend      = 1'b1;
                pend_cnt  = rv_delay;
                pend_addr = imem_addr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        if_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        gnt_en      = 1'b1;
        rv_delay    = 1;
        use_late    = 1'b0;

        step();
        step();
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_instr", if_instruction, 32'h0);

        // Zero-wait streaming from reset
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("first_req",  {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        step();
        check("no_early_valid", {31'h0, if_valid}, 32'h0);
        step();
        check("first_valid", {31'h0, if_valid}, 32'h1);
        check("first_pc",    if_pc, 32'h0);
        check("first_instr", if_instruction, mem_word(32'h0));
        for (int k = 1; k <= 3; k++) begin
            step();
            check("stream_req",  {31'h0, imem_req}, 32'h1);
            check("stream_addr", imem_addr, k);
            step();
            step();
            check("stream_valid", {31'h0, if_valid}, 32'h1);
            check("stream_pc",    if_pc, k);
            check("stream_instr", if_instruction, mem_word(k));
        end

        // Backpressure in HOLD
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_pc",    if_pc, 32'h3);
            check("stall_instr", if_instruction, mem_word(32'h3));
            check("stall_req",   {31'h0, imem_req}, 32'h0);
        end
        if_ready = 1'b1;
        step();
        check("resume_req",  {31'h0, imem_req}, 32'h1);
        check("resume_addr", imem_addr, 32'h4);
        step();
        step();
        check("resume_pc", if_pc, 32'h4);

        // Redirect while WAIT with a slow response
        rv_delay = 4;
        step();
        check("pre_redir_addr", imem_addr, 32'h5);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        rv_delay = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stale_valid", {31'h0, if_valid}, 32'h0);
        end
        check("redir_wait_req",  {31'h0, imem_req}, 32'h1);
        check("redir_wait_addr", imem_addr, 32'h40);
        step();
        step();
        check("redir_wait_pc",    if_pc, 32'h40);
        check("redir_wait_instr", if_instruction, mem_word(32'h40));

        // Redirect in HOLD with if_ready high: flush, no transfer
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        check("flush_valid", {31'h0, if_valid}, 32'h0);
        check("flush_req",   {31'h0, imem_req}, 32'h1);
        check("flush_addr",  imem_addr, 32'h80);
        step();
        step();
        check("flush_pc",    if_pc, 32'h80);
        check("flush_instr", if_instruction, mem_word(32'h80));

        // Halt raised during WAIT
        step();
        check("halt_pre_addr", imem_addr, 32'h81);
        step();
        halt = 1'b1;
        step();
        check("halt_deliver_valid", {31'h0, if_valid}, 32'h1);
        check("halt_deliver_pc",    if_pc, 32'h81);
        step();
        check("halted_valid", {31'h0, if_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("halted_req", {31'h0, imem_req}, 32'h0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        halt     = 1'b0;
        check("unhalt_req",  {31'h0, imem_req}, 32'h1);
        check("unhalt_addr", imem_addr, 32'h10);
        step();
        step();
        check("unhalt_pc",    if_pc, 32'h10);
        check("unhalt_instr", if_instruction, mem_word(32'h10));

        // Reset with a request outstanding, then a late response
        step();
        check("prereset_addr", imem_addr, 32'h11);
        rv_delay = 3;
        use_late = 1'b1;
        step();
        rst_n  = 1'b0;
        gnt_en = 1'b0;
        #1;
        check("midrst_req",   {31'h0, imem_req}, 32'h0);
        check("midrst_addr",  imem_addr, 32'h0);
        check("midrst_valid", {31'h0, if_valid}, 32'h0);
        check("midrst_pc",    if_pc, 32'h0);
        check("midrst_instr", if_instruction, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("late_valid", {31'h0, if_valid}, 32'h0);
            check("late_instr", if_instruction, 32'h0);
        end
        check("restart_req",  {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h0);
        use_late = 1'b0;
        rv_delay = 1;
        gnt_en   = 1'b1;
        wait_valid("restart_valid");
        check("restart_pc",    if_pc, 32'h0);
        check("restart_instr", if_instruction, mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
